pulse_sync_dst_mc: RTL and testbench
====================================

Name: pulse_sync_dst_mc

Overview:
- Parametrised destination-domain half of a toggle-based pulse synchronizer, generalised to N_CH channels.
- Each channel receives an asynchronous toggle from a source-domain pulse_sync_src-style block and synchronizes it through STAGES flops.
- Each channel regenerates a one-cycle pulse and returns an ack level for busy handshaking.
- A per-channel pending counter feeds a round-robin event queue (valid/ready with channel ID), so no event is lost while the consumer stalls.

Parameters:
- N_CH, 4, number of independent channels (1..32).
- STAGES, 2, synchronizer depth per channel (2..4).
- CNT_W, 4, pending-event counter width per channel; saturates at 2^CNT_W-1.
- ID_W, derived localparam = max(1, clog2(N_CH)), channel ID width.

Ports:
- clk_dst  in  1  destination clock; the only clock of this block.
- rst_n  in  1  reset, asynchronous assert, active-low; already synchronized to clk_dst by rst_sync upstream.
- tq  in  N_CH  asynchronous toggle per channel from the source domain.
- ack  out  N_CH  per-channel consumed-toggle level, returned to the source for busy/handshake.
- d_out  out  N_CH  one-cycle pulse per detected toggle.
- ev_valid  out  1  queued event available.
- ev_id  out  ID_W  channel of the presented event.
- ev_ready  in  1  consumer accepts the event when ev_valid && ev_ready at a rising edge.
- ovf  out  N_CH  sticky per-channel overflow flag.
- ovf_clr  in  N_CH  per-channel overflow clear, one cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchronizer flops, tq_d, ack, d_out, pending counters, ovf, ev_valid, ev_id and the RR pointer go to 0.
- Synchronizer: tq[i] passes through STAGES flops to give tq_s[i]. tq_d[i] <= tq_s[i]. evt[i] = tq_s[i] ^ tq_d[i].
- d_out[i] <= evt[i].
  - High exactly one cycle per toggle.
  - Latency: STAGES+1 clk_dst edges after the edge that first samples the new tq level.
- ack[i] = tq_d[i] (registered).
  - Source treats ack != its own toggle as busy.
  - ack changes on the same edge that d_out rises.
- Pending counter pend[i], updated on the edge where d_out[i] rises:
  - evt only: +1.
  - Pop of channel i (load into output slot) only: -1.
  - evt and pop in the same cycle: unchanged.
  - evt at saturation without a pop: event dropped, pend unchanged, ovf[i] <= 1.
- ovf[i]: sticky; cleared by ovf_clr[i]. Set and clear in the same cycle: set wins.
- Output slot (registered ev_valid/ev_id):
  - It loads when (!ev_valid || ev_ready) and any pend[i] != 0.
  - The channel is chosen round-robin, searching from (last granted id + 1) mod N_CH and wrapping.
  - A load decrements the chosen pend. ev_valid <= 1, ev_id <= granted id.
  - If nothing is pending and the slot is consumed or empty, ev_valid <= 0.
  - While ev_valid && !ev_ready, ev_valid and ev_id hold stable.
  - Back-to-back accepts sustain 1 event per cycle.
- Latency from d_out pulse to ev_valid: 1 cycle when the slot is free.
- The RR pointer updates only on a load.
- A single channel with pend=0 and evt in the same cycle as a slot-free condition is not loaded that cycle; it loads the next cycle.
- tq toggling faster than STAGES+1 cycles: toggles may merge (source contract violation). This is not detected; behaviour stays bounded: at most one evt per cycle per channel.
- Reset mid-operation: all pending events are discarded, and ack returns to 0. The source must also be reset (shared rst_n).
- STAGES < 2 or N_CH < 1 is illegal; elaboration halts.

Decomposition:
- The shared header/package (pulse_sync_pkg) holds:
  - clog2 function
  - STAGES_MIN=2
  - STAGES_MAX=4
  - N_CH_MAX=32
- One sub-module, rr_arb: N-bit request vector plus pointer → one-hot grant and encoded ID, purely combinational with the pointer register in the parent.
- The synchronizer chain is a generate loop, not a sub-module.

Test Plan:
- Reset, then one toggle on tq[0] with STAGES=2 → d_out[0] high for 1 cycle at edge 3 after sampling; ack[0]=1 on the same edge; ev_valid=1, ev_id=0 one cycle later; an accept with ev_ready=1 clears ev_valid.
- ev_ready=0, toggle ch1 three times (spaced 4 cycles apart) and ch3 twice → pend1=3, pend3=2; then ev_ready=1 → ev_id sequence 1,3,1,3,1 on consecutive cycles, followed by ev_valid=0.
- CNT_W=2, ev_ready=0, 5 toggles on ch2 → pend2 saturates at 3; the slot holds 1; ovf[2]=1 after the 5th; ovf_clr[2] pulse → ovf[2]=0; ovf_clr coinciding with a new overflow → ovf stays 1.
- Stall hold: ev_valid=1, ev_id=2, ev_ready=0 for 10 cycles while ch0 toggles → ev_id stays 2 throughout; ch0 is served next after release.
- Simultaneous: a ch0 evt on the same cycle its slot load pops pend0=1 → pend0 stays 1, with no lost or duplicated event; the total accepted count equals the total toggles.
- Assert rst_n low mid-queue (pend nonzero, ev_valid=1) → all outputs are 0 asynchronously; after release, no stale events appear.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
// Shared constants and helpers for the pulse synchronizer family.
package pulse_sync_pkg;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int N_CH_MAX   = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first request after ptr, wrapping to 0.
module rr_arb
  import pulse_sync_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] id,
  output logic            any
);
  // Two passes: channels above ptr win first, then the lowest at or below it.
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i > int'(ptr))) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        id     = ID_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        id     = ID_W'(i);
      end
    end
  end
endmodule

// File: rtl/pulse_sync_dst_mc.sv
// Multi-channel destination half of a toggle pulse synchronizer with a
// per-channel pending counter and a round-robin event queue.
module pulse_sync_dst_mc
  import pulse_sync_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int STAGES = 2,
  parameter  int CNT_W  = 4,
  localparam int ID_W   = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
  input  logic            clk_dst,
  input  logic            rst_n,
  input  logic [N_CH-1:0] tq,
  output logic [N_CH-1:0] ack,
  output logic [N_CH-1:0] d_out,
  output logic            ev_valid,
  output logic [ID_W-1:0] ev_id,
  input  logic            ev_ready,
  output logic [N_CH-1:0] ovf,
  input  logic [N_CH-1:0] ovf_clr
);
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $fatal(1, "pulse_sync_dst_mc: STAGES out of range");
  end
  if (N_CH < 1 || N_CH > N_CH_MAX) begin : g_bad_nch
    $fatal(1, "pulse_sync_dst_mc: N_CH out of range");
  end

  logic [N_CH-1:0]            tq_s, tq_d, evt;
  logic [N_CH-1:0][CNT_W-1:0] pend;
  logic [N_CH-1:0]            req, gnt, pop, ovf_set;
  logic [ID_W-1:0]            gnt_id;
  logic                       gnt_any, load;

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    logic [STAGES-1:0] sr;
    always_ff @(posedge clk_dst or negedge rst_n) begin
      if (!rst_n) sr <= '0;
      else        sr <= {sr[STAGES-2:0], tq[i]};
    end
    assign tq_s[i] = sr[STAGES-1];
    assign req[i]  = |pend[i];
  end

  assign evt = tq_s ^ tq_d;
  assign ack = tq_d;

  // ev_id doubles as the round-robin pointer: both change only on a load.
  rr_arb #(.N(N_CH), .ID_W(ID_W)) u_arb (
    .req (req),
    .ptr (ev_id),
    .gnt (gnt),
    .id  (gnt_id),
    .any (gnt_any)
  );

  assign load = (!ev_valid || ev_ready) && gnt_any;
  assign pop  = load ? gnt : '0;

  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < N_CH; i++)
      ovf_set[i] = evt[i] && !pop[i] && (&pend[i]);
  end

  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      tq_d  <= '0;
      d_out <= '0;
      pend  <= '0;
      ovf   <= '0;
    end else begin
      tq_d  <= tq_s;
      d_out <= evt;
      for (int i = 0; i < N_CH; i++) begin
        if (evt[i] && !pop[i] && !(&pend[i])) pend[i] <= pend[i] + CNT_W'(1);
        else if (pop[i] && !evt[i])           pend[i] <= pend[i] - CNT_W'(1);
        if (ovf_set[i])      ovf[i] <= 1'b1;
        else if (ovf_clr[i]) ovf[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_id    <= '0;
    end else if (load) begin
      ev_valid <= 1'b1;
      ev_id    <= gnt_id;
    end else if (ev_ready) begin
      ev_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pulse_sync_dst_mc.sv
// Bench for pulse_sync_dst_mc: vector table, directed corner sequences and
// randomized traffic checked against a delay-line/queue reference model.
module tb_pulse_sync_dst_mc;
  localparam int N_CH = 4, STAGES = 2, CNT_W = 2, ID_W = 2;
  localparam int PMAX = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] tq, ack, d_out, ovf, ovf_clr;
  logic            ev_valid, ev_ready;
  logic [ID_W-1:0] ev_id;

  int vec = 0, miss = 0, acc_cnt = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pulse_sync_dst_mc #(.N_CH(N_CH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk_dst(clk), .rst_n(rst_n), .tq(tq), .ack(ack), .d_out(d_out),
    .ev_valid(ev_valid), .ev_id(ev_id), .ev_ready(ev_ready),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: tq samples in a delay line, integer pending counts,
  // and a search loop over channels for the round-robin pick.
  logic [N_CH-1:0] h [STAGES+1];
  int              m_pend [N_CH];
  logic [N_CH-1:0] m_d, m_ack, m_ovf;
  logic            m_valid;
  int              m_id;

  always @(posedge clk or negedge rst_n) begin : model
    logic [N_CH-1:0] e;
    int g, idx;
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) h[k] <= '0;
      for (int i = 0; i < N_CH; i++) m_pend[i] <= 0;
      m_d <= '0; m_ack <= '0; m_ovf <= '0; m_valid <= 1'b0; m_id <= 0;
    end else begin
      e = h[STAGES-1] ^ h[STAGES];
      m_d   <= e;
      m_ack <= h[STAGES-1];
      for (int k = STAGES; k > 0; k--) h[k] <= h[k-1];
      h[0] <= tq;
      g = -1;
      if (!m_valid || ev_ready)
        for (int k = 1; k <= N_CH; k++) begin
          idx = (m_id + k) % N_CH;
          if (g < 0 && m_pend[idx] > 0) g = idx;
        end
      for (int i = 0; i < N_CH; i++) begin
        if (e[i] && g != i && m_pend[i] == PMAX) m_ovf[i] <= 1'b1;
        else if (ovf_clr[i])                     m_ovf[i] <= 1'b0;
        if (e[i] && g != i && m_pend[i] < PMAX)  m_pend[i] <= m_pend[i] + 1;
        else if (!e[i] && g == i)                m_pend[i] <= m_pend[i] - 1;
      end
      if (g >= 0) begin
        m_valid <= 1'b1;
        m_id    <= g;
      end else if (ev_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(posedge clk)
    if (rst_n && ev_valid && ev_ready) acc_cnt <= acc_cnt + 1;

  always @(negedge clk)
    if (rst_n && chk_on) begin
      chk("m_d_out", d_out, m_d);
      chk("m_ack", ack, m_ack);
      chk("m_ev_valid", ev_valid, m_valid);
      chk("m_ev_id", ev_id, m_id[ID_W-1:0]);
      chk("m_ovf", ovf, m_ovf);
    end

  typedef struct packed {
    logic [N_CH-1:0] tq;
    logic            rdy;
    logic [N_CH-1:0] d, a;
    logic            v;
    logic [ID_W-1:0] id;
  } row_t;

  row_t tbl [6];
  int   exp_ids [5];
  int   acc0, ntog;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tq = '0; ev_ready = 1'b0; ovf_clr = '0;
    cyc(3);
    chk("rst_ack", ack, 0);
    chk("rst_dout", d_out, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_id", ev_id, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1; chk_on = 1'b1;
    cyc(1);

    // single toggle on ch0: pulse at 3rd edge after sampling, queue 1 cycle later
    tbl[0] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[1] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[2] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0};
    tbl[3] = '{4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd0};
    tbl[4] = '{4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd0};
    tbl[5] = '{4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b0, 2'd0};
    for (int r = 0; r < 6; r++) begin
      tq = tbl[r].tq; ev_ready = tbl[r].rdy;
      cyc(1);
      chk($sformatf("tbl%0d_dout", r), d_out, tbl[r].d);
      chk($sformatf("tbl%0d_ack", r), ack, tbl[r].a);
      chk($sformatf("tbl%0d_valid", r), ev_valid, tbl[r].v);
      if (tbl[r].v) chk($sformatf("tbl%0d_id", r), ev_id, tbl[r].id);
    end

    // round robin: ch1 x3, ch3 x2 queued under stall
    ev_ready = 1'b0;
    tq[1] = ~tq[1]; tq[3] = ~tq[3]; cyc(4);
    tq[1] = ~tq[1]; tq[3] = ~tq[3]; cyc(4);
    tq[1] = ~tq[1]; cyc(5);
    exp_ids = '{1, 3, 1, 3, 1};
    ev_ready = 1'b1;
    chk("rr_v0", ev_valid, 1);
    chk("rr_id0", ev_id, exp_ids[0]);
    for (int j = 1; j < 5; j++) begin
      cyc(1);
      chk($sformatf("rr_v%0d", j), ev_valid, 1);
      chk($sformatf("rr_id%0d", j), ev_id, exp_ids[j]);
    end
    cyc(1);
    chk("rr_empty", ev_valid, 0);
    ev_ready = 1'b0;

    // saturation and sticky overflow on ch2
    acc0 = acc_cnt;
    for (int j = 0; j < 4; j++) begin
      tq[2] = ~tq[2]; cyc(4);
    end
    chk("sat_noovf", ovf, 0);
    tq[2] = ~tq[2]; cyc(4);
    chk("sat_ovf", ovf, 4'b0100);
    chk("sat_slot", {ev_valid, ev_id}, {1'b1, 2'd2});
    ovf_clr = 4'b0100; cyc(1); ovf_clr = '0;
    chk("ovf_clr", ovf, 0);
    tq[2] = ~tq[2]; cyc(2);
    ovf_clr = 4'b0100; cyc(1); ovf_clr = '0;
    chk("ovf_coin_pulse", d_out[2], 1);
    chk("ovf_set_wins", ovf[2], 1);
    ovf_clr = 4'b0100; cyc(1); ovf_clr = '0;
    chk("ovf_clr2", ovf, 0);
    ev_ready = 1'b1; cyc(8);
    chk("sat_drain", acc_cnt - acc0, PMAX + 1);
    chk("sat_empty", ev_valid, 0);
    ev_ready = 1'b0;

    // stall hold with ch2 presented while ch0 arrives
    tq[2] = ~tq[2];
    for (int k = 0; k < 10 && !ev_valid; k++) cyc(1);
    chk("hold_load", {ev_valid, ev_id}, {1'b1, 2'd2});
    tq[0] = ~tq[0];
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk($sformatf("hold%0d", k), {ev_valid, ev_id}, {1'b1, 2'd2});
    end
    ev_ready = 1'b1; cyc(1);
    chk("hold_next", {ev_valid, ev_id}, {1'b1, 2'd0});
    cyc(1);
    chk("hold_empty", ev_valid, 0);
    ev_ready = 1'b0;

    // ch0 event lands on the edge that pops its single pending entry
    acc0 = acc_cnt; ntog = 0;
    tq[0] = ~tq[0]; ntog++; cyc(4);
    tq[0] = ~tq[0]; ntog++; cyc(4);
    tq[0] = ~tq[0]; ntog++; cyc(2);
    ev_ready = 1'b1; cyc(1); ev_ready = 1'b0;
    chk("simul_pulse", d_out[0], 1);
    chk("simul_slot", {ev_valid, ev_id}, {1'b1, 2'd0});
    ev_ready = 1'b1; cyc(6);
    chk("simul_total", acc_cnt - acc0, ntog);
    chk("simul_empty", ev_valid, 0);

    // randomized traffic, including toggles faster than the source contract
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 7) == 0) tq[i] = ~tq[i];
        ovf_clr[i] = ($urandom_range(0, 15) == 0);
      end
      ev_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    ovf_clr = '0;

    // reset mid-queue
    ev_ready = 1'b0;
    tq[1] = ~tq[1]; tq[3] = ~tq[3]; cyc(4);
    tq[1] = ~tq[1]; tq[3] = ~tq[3]; cyc(4);
    chk("pre_rst_valid", ev_valid, 1);
    #2;
    rst_n = 1'b0; tq = '0;
    #1;
    chk("arst_ack", ack, 0);
    chk("arst_dout", d_out, 0);
    chk("arst_valid", ev_valid, 0);
    chk("arst_id", ev_id, 0);
    chk("arst_ovf", ovf, 0);
    cyc(2);
    rst_n = 1'b1; ev_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk($sformatf("post_rst%0d", k), {ev_valid, d_out}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
